// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port, variable-latency memory between the fetch port
// and the data port. Data has priority; a grant streak limit keeps fetch alive.
//
// state | meaning
// IDLE  | no access in flight; arbitrates on each edge
// FETCH | fetch access in flight; mem_* held until mem_ready
// DATA  | data access in flight; mem_* held until mem_ready
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_f,
  output logic          stall_m
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  state_t        state, stateNext;
  logic [SW-1:0] streak, streakNext;
  logic          memReqNext, memWeNext;
  logic [AW-1:0] memAddrNext;
  logic [DW-1:0] memWdataNext, ifRdataNext, dRdataNext;
  logic          ifValidNext, dValidNext;
  logic          dGrant;

  // Data loses only when fetch is waiting and has already been passed over LIMIT times
  assign dGrant  = d_req & ~(if_req & (streak == LIMIT));
  assign stall_f = if_req & ~if_valid;
  assign stall_m = d_req & ~d_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      streak    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      state     <= stateNext;
      streak    <= streakNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      if_rdata  <= ifRdataNext;
      d_rdata   <= dRdataNext;
      if_valid  <= ifValidNext;
      d_valid   <= dValidNext;
    end
  end

  always_comb begin
    stateNext    = state;
    streakNext   = streak;
    memReqNext   = mem_req;
    memWeNext    = mem_we;
    memAddrNext  = mem_addr;
    memWdataNext = mem_wdata;
    ifRdataNext  = if_rdata;
    dRdataNext   = d_rdata;
    ifValidNext  = 1'b0;
    dValidNext   = 1'b0;
    case (state)
      IDLE: begin
        if (dGrant) begin
          stateNext    = DATA;
          memReqNext   = 1'b1;
          memWeNext    = d_we;
          memAddrNext  = d_addr;
          memWdataNext = d_wdata;
          if (!if_req)              streakNext = '0;
          else if (streak != LIMIT) streakNext = streak + SW'(1);
        end else if (if_req) begin
          stateNext    = FETCH;
          memReqNext   = 1'b1;
          memWeNext    = 1'b0;
          memAddrNext  = if_addr;
          memWdataNext = '0;
          streakNext   = '0;
        end
      end
      FETCH: begin
        if (mem_ready) begin
          stateNext   = IDLE;
          memReqNext  = 1'b0;
          ifRdataNext = mem_rdata;
          ifValidNext = 1'b1;
        end
      end
      DATA: begin
        if (mem_ready) begin
          stateNext  = IDLE;
          memReqNext = 1'b0;
          dValidNext = 1'b1;
          if (!mem_we) dRdataNext = mem_rdata;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level arbitration model.
module tb_mem_port_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        stall_f;
  logic        stall_m;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m)
  );

  always #5 clk = ~clk;

  int errCount = 0;
  int checkCount = 0;

  // Transaction-level model: who owns memory, what was latched, what was returned
  logic        mdlBusy = 0;
  int          mdlOwner = 0;   // 1 = fetch, 2 = data
  int          mdlStreak = 0;
  logic        mdlWe = 0;
  logic [31:0] mdlAddr = '0, mdlWdata = '0, mdlIfRdata = '0, mdlDRdata = '0;
  logic        mdlIfValid = 0, mdlDValid = 0;
  int          lastGrant = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mdlReset();
    mdlBusy = 0; mdlOwner = 0; mdlStreak = 0; mdlWe = 0;
    mdlAddr = '0; mdlWdata = '0; mdlIfRdata = '0; mdlDRdata = '0;
    mdlIfValid = 0; mdlDValid = 0; lastGrant = 0;
  endtask

  // Inputs set now are sampled at the coming rising edge; check at the falling edge after it
  task automatic step();
    logic sIf, sD, sDWe, sReady;
    logic [31:0] sIfA, sDA, sDW, sRd;
    sIf = if_req; sD = d_req; sDWe = d_we; sReady = mem_ready;
    sIfA = if_addr; sDA = d_addr; sDW = d_wdata; sRd = mem_rdata;
    @(negedge clk);
    mdlIfValid = 0; mdlDValid = 0; lastGrant = 0;
    if (!mdlBusy) begin
      if (sD && !(sIf && mdlStreak == LIMIT)) begin
        mdlBusy = 1; mdlOwner = 2; lastGrant = 2;
        mdlWe = sDWe; mdlAddr = sDA; mdlWdata = sDW;
        mdlStreak = sIf ? ((mdlStreak < LIMIT) ? mdlStreak + 1 : LIMIT) : 0;
      end else if (sIf) begin
        mdlBusy = 1; mdlOwner = 1; lastGrant = 1;
        mdlWe = 0; mdlAddr = sIfA; mdlWdata = '0; mdlStreak = 0;
      end
    end else if (sReady) begin
      mdlBusy = 0;
      if (mdlOwner == 1) begin
        mdlIfValid = 1; mdlIfRdata = sRd;
      end else begin
        mdlDValid = 1;
        if (!mdlWe) mdlDRdata = sRd;
      end
    end
    checkVal("mem_req", mem_req, mdlBusy);
    checkVal("mem_we", mem_we, mdlWe);
    checkVal("mem_addr", mem_addr, mdlAddr);
    checkVal("mem_wdata", mem_wdata, mdlWdata);
    checkVal("if_valid", if_valid, mdlIfValid);
    checkVal("d_valid", d_valid, mdlDValid);
    checkVal("if_rdata", if_rdata, mdlIfRdata);
    checkVal("d_rdata", d_rdata, mdlDRdata);
    checkVal("stall_f", stall_f, if_req & ~mdlIfValid);
    checkVal("stall_m", stall_m, d_req & ~mdlDValid);
    checkVal("one_valid", if_valid & d_valid, 0);
  endtask

  initial begin
    int expOrder[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    int nGrant;
    int dPulses;
    logic ifAbandon, dAbandon;

    #12;
    checkVal("rst_mem_req", mem_req, 0);
    checkVal("rst_if_valid", if_valid, 0);
    checkVal("rst_d_valid", d_valid, 0);
    checkVal("rst_mem_addr", mem_addr, 0);
    checkVal("rst_d_rdata", d_rdata, 0);
    @(negedge clk);
    reset = 1'b1;
    step();

    // Single fetch, zero-wait memory
    if_req = 1; if_addr = 32'h10; mem_ready = 1; mem_rdata = 32'hE3A00005;
    step();
    checkVal("t1_mem_req", mem_req, 1);
    checkVal("t1_mem_we", mem_we, 0);
    step();
    checkVal("t1_if_valid", if_valid, 1);
    checkVal("t1_if_rdata", if_rdata, 32'hE3A00005);
    checkVal("t1_mem_req_off", mem_req, 0);
    if_req = 0; mem_ready = 0;
    step();

    // Data write, memory ready in cycle 3
    d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hAB;
    #1 checkVal("t2_stall_m_c0", stall_m, 1);
    step(); step(); step();
    checkVal("t2_mem_addr_c3", mem_addr, 32'h40);
    checkVal("t2_mem_wdata_c3", mem_wdata, 32'hAB);
    mem_ready = 1; mem_rdata = 32'hDEAD;
    step();
    checkVal("t2_d_valid", d_valid, 1);
    checkVal("t2_d_rdata_kept", d_rdata, 0);
    d_req = 0; d_we = 0; mem_ready = 0;
    step();

    // Contention with zero-wait memory
    if_req = 1; if_addr = 32'h100; d_req = 1; d_we = 0; d_addr = 32'h200; mem_ready = 1;
    nGrant = 0;
    for (int c = 0; c < 60 && nGrant < 10; c++) begin
      mem_rdata = $urandom;
      step();
      if (lastGrant != 0) begin
        checkVal("t3_grant_owner", (mem_addr == 32'h200) ? 2 : 1, expOrder[nGrant]);
        nGrant++;
      end
    end
    checkVal("t3_grant_count", nGrant, 10);
    if_req = 0; d_req = 0;
    step(); step(); step();

    // Reset in the middle of a data access
    mem_ready = 0; d_req = 1; d_we = 0; d_addr = 32'h44;
    step(); step();
    #2 reset = 1'b0;
    #1 checkVal("t4_async_mem_req", mem_req, 0);
    @(negedge clk);
    checkVal("t4_rst_d_valid", d_valid, 0);
    reset = 1'b1;
    mdlReset();
    mem_ready = 1; mem_rdata = 32'h55;
    dPulses = 0;
    step(); dPulses += int'(d_valid);
    step(); dPulses += int'(d_valid);
    checkVal("t4_d_rdata", d_rdata, 32'h55);
    d_req = 0;
    for (int c = 0; c < 3; c++) begin
      step(); dPulses += int'(d_valid);
    end
    checkVal("t4_single_pulse", dPulses, 1);
    mem_ready = 0;

    // Abandoned fetch
    if_req = 1; if_addr = 32'h300;
    step();
    step();
    if_req = 0;
    #1 checkVal("t5_stall_f_c2", stall_f, 0);
    step();
    mem_ready = 1; mem_rdata = 32'h777;
    step();
    checkVal("t5_if_valid_c4", if_valid, 1);
    checkVal("t5_idle_c4", mem_req, 0);
    mem_ready = 0;
    step();

    // Read data held through a following fetch
    d_req = 1; d_we = 0; d_addr = 32'h80; mem_ready = 1; mem_rdata = 32'h1234;
    step(); step();
    checkVal("t6_d_rdata", d_rdata, 32'h1234);
    d_req = 0; if_req = 1; if_addr = 32'h84; mem_rdata = 32'hCAFE;
    step(); step();
    checkVal("t6_d_rdata_hold", d_rdata, 32'h1234);
    checkVal("t6_if_rdata", if_rdata, 32'hCAFE);
    if_req = 0; mem_ready = 0;
    step();

    // Random traffic from both requesters
    ifAbandon = 0; dAbandon = 0;
    for (int c = 0; c < 3000; c++) begin
      if (if_req) begin
        if (if_valid) begin
          if ($urandom_range(0, 1) == 1) if_addr = $urandom;
          else if_req = 0;
        end else if (mdlBusy && mdlOwner == 1 && $urandom_range(0, 15) == 0) begin
          if_req = 0; ifAbandon = 1;
        end
      end else if (ifAbandon) begin
        if (if_valid) ifAbandon = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      if (d_req) begin
        if (d_valid) begin
          if ($urandom_range(0, 1) == 1) begin
            d_we = ($urandom_range(0, 1) == 1); d_addr = $urandom; d_wdata = $urandom;
          end else d_req = 0;
        end else if (mdlBusy && mdlOwner == 2 && $urandom_range(0, 15) == 0) begin
          d_req = 0; dAbandon = 1;
        end
      end else if (dAbandon) begin
        if (d_valid) dAbandon = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = ($urandom_range(0, 1) == 1); d_addr = $urandom; d_wdata = $urandom;
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
